// File: rtl/flex_countdown_timer.sv
//----------------------------------------------------------------------------
// flex_countdown_timer
//
// Loadable down-counter with a start/busy/done handshake. A controller loads a
// count with start. The block then decrements on each count_enable strobe and
// reports completion with a registered one-cycle done pulse.
//
// Build option:
//   FLEX_TIMER_AUTORELOAD_EN  When defined, the block runs in periodic mode.
//                             The terminal strobe reloads the count from the
//                             value captured at start, pulses done and stays
//                             in RUN. Abort or reset ends the periodic run.
//                             When undefined, the block is a one-shot timer.
//
// Parameters:
//   NUM_CNT_BITS  width of load_val / count_out (>= 2), default 4
//
// Ports:
//   clk           in   rising-edge clock
//   n_rst         in   asynchronous active-low reset
//   start         in   load load_val and begin counting (IDLE/DONE only)
//   load_val      in   initial count, unsigned
//   count_enable  in   decrement strobe (RUN only)
//   abort         in   synchronous cancel, highest priority after reset
//   count_out     out  remaining count (registered)
//   busy          out  high while counting (registered)
//   done          out  one-cycle completion pulse (registered)
//----------------------------------------------------------------------------
module flex_countdown_timer #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    abort,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [NUM_CNT_BITS-1:0] count_r;
  logic                    busy_r;
  logic                    done_r;

`ifdef FLEX_TIMER_AUTORELOAD_EN
  // Count captured on the accepted start, used to restart each period.
  logic [NUM_CNT_BITS-1:0] reload_r;
`endif

  // Timer state machine: state, remaining count and registered busy/done flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r  <= IDLE;
      count_r  <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef FLEX_TIMER_AUTORELOAD_EN
      reload_r <= CNT_ZERO;
`endif
    end else if (abort) begin
      // Abort cancels everything, including a pending terminal strobe,
      // so no done pulse is produced. The reload value is left untouched
      // because it is only ever used after a fresh start.
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // DONE behaves like IDLE so that a start can be accepted during
          // the done cycle for back-to-back timing with no idle gap.
          if (start) begin
`ifdef FLEX_TIMER_AUTORELOAD_EN
            reload_r <= load_val;
`endif
            if (load_val != CNT_ZERO) begin
              state_r <= RUN;
              count_r <= load_val;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end else begin
`ifdef FLEX_TIMER_AUTORELOAD_EN
              // A zero period is meaningless in periodic mode: stay idle.
              state_r <= IDLE;
              count_r <= CNT_ZERO;
              busy_r  <= 1'b0;
              done_r  <= 1'b0;
`else
              // Zero-length wait completes immediately.
              state_r <= DONE;
              count_r <= CNT_ZERO;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
`endif
            end
          end else begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end

        RUN: begin
          if (count_enable) begin
            // count_r is never 0 in RUN, so "<= 1" is the terminal strobe.
            // Using "<=" rather than "==" also keeps the counter from ever
            // wrapping should RUN somehow be reached with a zero count.
            if (count_r <= CNT_ONE) begin
`ifdef FLEX_TIMER_AUTORELOAD_EN
              state_r <= RUN;
              count_r <= reload_r;
              busy_r  <= 1'b1;
              done_r  <= 1'b1;
`else
              state_r <= DONE;
              count_r <= CNT_ZERO;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
`endif
            end else begin
              state_r <= RUN;
              count_r <= count_r - CNT_ONE;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            // No strobe: hold the count. Any autoreload done pulse ends here.
            state_r <= RUN;
            count_r <= count_r;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: recover to a safe idle state.
          state_r <= IDLE;
          count_r <= CNT_ZERO;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count_out = count_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_flex_countdown_timer.sv
//----------------------------------------------------------------------------
// Scoreboard bench for flex_countdown_timer.
// The stimulus side drives inputs on the falling edge. It advances a
// behavioural model of the timer rules and queues the outputs expected after
// the next rising edge. A separate monitor pops one entry per rising edge and
// compares it with the DUT.
//----------------------------------------------------------------------------
module tb_flex_countdown_timer;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         count_enable;
  logic         abort;
  logic [W-1:0] count_out;
  logic         busy;
  logic         done;

  flex_countdown_timer #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .load_val     (load_val),
    .count_enable (count_enable),
    .abort        (abort),
    .count_out    (count_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         bsy;
    logic         dne;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: how many strobes are still owed, whether a wait is
  // in progress, and whether this cycle is a completion cycle.
  int m_remaining = 0;
  bit m_counting  = 1'b0;
  bit m_pulse     = 1'b0;
  int m_period    = 0;

`ifdef FLEX_TIMER_AUTORELOAD_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  function automatic void model_step(input bit rstn, input bit st, input int lv,
                                     input bit ce, input bit ab);
    if (!rstn) begin
      m_counting = 1'b0; m_remaining = 0; m_pulse = 1'b0; m_period = 0;
    end else if (ab) begin
      m_counting = 1'b0; m_remaining = 0; m_pulse = 1'b0;
    end else if (!m_counting) begin
      m_pulse = 1'b0;
      m_remaining = 0;
      if (st) begin
        m_period = lv;
        if (lv != 0) begin
          m_counting  = 1'b1;
          m_remaining = lv;
        end else begin
          m_pulse = !PERIODIC;
        end
      end
    end else begin
      m_pulse = 1'b0;
      if (ce) begin
        if (m_remaining == 1) begin
          m_pulse = 1'b1;
          if (PERIODIC) begin
            m_remaining = m_period;
          end else begin
            m_remaining = 0;
            m_counting  = 1'b0;
          end
        end else begin
          m_remaining = m_remaining - 1;
        end
      end
    end
  endfunction

  // One clock cycle of stimulus.
  task automatic cycle(input bit rstn, input bit st, input int lv, input bit ce, input bit ab);
    bit   prev_rstn;
    exp_t e;
    int   lv_c;
    @(negedge clk);
    lv_c         = lv;
    prev_rstn    = n_rst;
    n_rst        = rstn;
    start        = st;
    load_val     = lv_c[W-1:0];
    count_enable = ce;
    abort        = ab;
    if (prev_rstn && !rstn) begin
      // Reset must clear the outputs at once, without waiting for a clock.
      #1;
      checks++;
      if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: got cnt=%0d busy=%0b done=%0b, want 0 0 0",
                 count_out, busy, done);
      end
    end
    model_step(rstn, st, lv, ce, ab);
    e.cnt = m_remaining[W-1:0];
    e.bsy = m_counting;
    e.dne = m_pulse;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (count_out !== e.cnt || busy !== e.bsy || done !== e.dne) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got cnt=%0d busy=%0b done=%0b, want cnt=%0d busy=%0b done=%0b",
                   $time, count_out, busy, done, e.cnt, e.bsy, e.dne);
        end
      end
    end
  end

  initial begin
    int lv;
    n_rst = 1'b0; start = 1'b0; load_val = '0; count_enable = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset: got cnt=%0d busy=%0b done=%0b, want 0 0 0",
               count_out, busy, done);
    end

    // Reset for 2 cycles, then idle.
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(10);

    // One-shot with strobes held high.
    cycle(1'b1, 1'b1, 5, 1'b1, 1'b0);
    strobes(7);
    idle(2);

    // Gapped strobes every 3rd cycle.
    cycle(1'b1, 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0, (i % 3) == 2, 1'b0);

    // Same again with abort on the 2nd strobe cycle.
    cycle(1'b1, 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0, (i % 3) == 2, i == 5);

    // Edge loads: zero and maximum.
    cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b1, MAXV, 1'b0, 1'b0);
    strobes(MAXV + 3);
    idle(2);

    // Back-to-back start during the done cycle; start in RUN is ignored.
    cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 9, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
    strobes(4);

    // Abort together with start, and abort together with the final strobe.
    cycle(1'b1, 1'b1, 4, 1'b0, 1'b1);
    idle(2);
    cycle(1'b1, 1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b1);
    idle(3);

    // Reset asserted mid-RUN at count 1, then no done after release.
    cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, MAXV);
      else lv = $urandom_range(0, 4);
      cycle($urandom_range(0, 499) != 0, $urandom_range(0, 7) == 0, lv,
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
